imem_loader: RTL

Program loader: the write side of the core's instruction memory. It accepts a framed byte stream from a UART receiver or host link, assembles little-endian 32-bit words and writes them into instruction memory. It holds the core in reset until a complete frame with a valid checksum has been loaded, then releases it. It sits between the byte-stream source and the instruction-memory write port, and drives the core's reset input.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles a framed, XOR-checksummed byte
// stream into little-endian words, writes them out and gates the core's reset.
module imem_loader #(
    parameter int         DEPTH     = 256,
    parameter int         ADDR_W    = $clog2(DEPTH),
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        S_SYNC, S_LEN0, S_LEN1, S_DATA, S_WR, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t              state_q;
    logic [15:0]         count_q;
    logic [ADDR_W:0]     widx_q;     // one extra bit so COUNT==DEPTH never wraps
    logic [1:0]          bidx_q;
    logic [31:0]         word_q;
    logic [7:0]          csum_q;
    logic                rx_ready_q, mem_we_q, core_reset_q, load_done_q, load_error_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic                accept;
    logic [31:0]         word_d;
    logic [7:0]          csum_d;
    logic [15:0]         count_d;
    logic                last_word;

    assign accept    = rx_valid && rx_ready_q;
    assign csum_d    = csum_q ^ rx_data;
    assign count_d   = {rx_data, count_q[7:0]};
    assign last_word = (16'(widx_q) + 16'd1) == count_q;

    always_comb begin
        word_d                 = word_q;
        word_d[8*bidx_q +: 8]  = rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_SYNC;
            count_q      <= '0;
            widx_q       <= '0;
            bidx_q       <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            rx_ready_q <= 1'b1;
            case (state_q)
                S_SYNC, S_DONE, S_ERR: begin
                    // Any non-sync byte here is line noise and is dropped.
                    if (accept && rx_data == SYNC_BYTE) begin
                        state_q      <= S_LEN0;
                        csum_q       <= '0;
                        widx_q       <= '0;
                        bidx_q       <= '0;
                        core_reset_q <= 1'b1;
                        load_done_q  <= 1'b0;
                        load_error_q <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (accept) begin
                        count_q <= {8'h00, rx_data};
                        state_q <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        count_q <= count_d;
                        if (count_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else if (count_d > 16'(DEPTH)) begin
                            state_q      <= S_ERR;
                            load_error_q <= 1'b1;
                            load_done_q  <= 1'b0;
                            core_reset_q <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q <= word_d;
                        csum_q <= csum_d;
                        if (bidx_q == 2'd3) begin
                            state_q     <= S_WR;
                            rx_ready_q  <= 1'b0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= widx_q[ADDR_W-1:0];
                            mem_wdata_q <= word_d;
                        end else begin
                            bidx_q <= bidx_q + 2'd1;
                        end
                    end
                end
                S_WR: begin
                    widx_q  <= widx_q + 1'b1;
                    bidx_q  <= '0;
                    state_q <= last_word ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            state_q      <= S_DONE;
                            core_reset_q <= 1'b0;
                            load_done_q  <= 1'b1;
                            load_error_q <= 1'b0;
                        end else begin
                            state_q      <= S_ERR;
                            core_reset_q <= 1'b1;
                            load_done_q  <= 1'b0;
                            load_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule
